ycbcr2rgb_pipe: RTL and testbench

Pipelined BT.601 full-range YCbCr 4:4:4 to RGB888 converter. It is the inverse-direction companion to the luma extraction path in the image pipeline. Accepts one pixel per cycle on a valid/ready stream and emits clamped 8-bit R/G/B on a valid/ready stream. Fixed-point Q8 coefficients; 4-stage pipeline with global stall for downstream backpressure.

---
 rtl/ycbcr2rgb_pipe.sv | 140 ++++++++++++++
 tb/tb_ycbcr2rgb_pipe.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/ycbcr2rgb_pipe.sv
// BT.601 full-range YCbCr 4:4:4 to RGB888 converter with Q8 coefficients.
// Four register stages share one clock enable, so downstream backpressure stalls the whole pipe.
module ycbcr2rgb_pipe #(
  parameter int DATA_W  = 8,
  parameter int COEF_W  = 11,
  parameter int COEF_RV = 359,
  parameter int COEF_GU = 88,
  parameter int COEF_GV = 183,
  parameter int COEF_BU = 454
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] y,
  input  logic [DATA_W-1:0] cb,
  input  logic [DATA_W-1:0] cr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] r,
  output logic [DATA_W-1:0] g,
  output logic [DATA_W-1:0] b
);

  localparam int FRAC = 8;
  localparam int PW   = COEF_W + DATA_W - 1;
  localparam int SW   = PW + 1;

  localparam logic signed [COEF_W-1:0] K_RV = COEF_W'(COEF_RV);
  localparam logic signed [COEF_W-1:0] K_GU = COEF_W'(COEF_GU);
  localparam logic signed [COEF_W-1:0] K_GV = COEF_W'(COEF_GV);
  localparam logic signed [COEF_W-1:0] K_BU = COEF_W'(COEF_BU);
  localparam logic signed [SW-1:0]     RND  = SW'(1 << (FRAC - 1));

  // Offset-128 removal: flipping the MSB yields the two's-complement value, then sign-extend.
  function automatic logic signed [DATA_W:0] center(input logic [DATA_W-1:0] v);
    logic [DATA_W-1:0] t;
    t = v ^ {1'b1, {(DATA_W-1){1'b0}}};
    return {t[DATA_W-1], t};
  endfunction

  function automatic logic signed [PW-1:0] mul(input logic signed [COEF_W-1:0] k,
                                               input logic signed [DATA_W:0]   x);
    return PW'(k) * PW'(x);
  endfunction

  function automatic logic [DATA_W-1:0] sat(input logic signed [SW-1:0] s);
    logic signed [SW-1:0] q;
    logic [DATA_W-1:0]    res;
    q = s >>> FRAC;
    if (q[SW-1])
      res = '0;
    else if (|q[SW-2:DATA_W])
      res = '1;
    else
      res = q[DATA_W-1:0];
    return res;
  endfunction

  logic ce;

  logic                     vld_p1;
  logic [DATA_W-1:0]        y_p1;
  logic signed [DATA_W:0]   cbs_p1;
  logic signed [DATA_W:0]   crs_p1;

  logic                     vld_p2;
  logic [DATA_W-1:0]        y_p2;
  logic signed [PW-1:0]     pr_p2;
  logic signed [PW-1:0]     pgu_p2;
  logic signed [PW-1:0]     pgv_p2;
  logic signed [PW-1:0]     pb_p2;

  logic                     vld_p3;
  logic signed [SW-1:0]     sr_p3;
  logic signed [SW-1:0]     sg_p3;
  logic signed [SW-1:0]     sb_p3;

  logic signed [SW-1:0]     yq;
  logic signed [SW-1:0]     sr_n;
  logic signed [SW-1:0]     sg_n;
  logic signed [SW-1:0]     sb_n;

  assign ce       = out_ready | ~out_valid;
  assign in_ready = ce;

  always_comb begin
    yq   = $signed({{(SW-DATA_W-FRAC){1'b0}}, y_p2, {FRAC{1'b0}}});
    sr_n = yq + SW'(pr_p2) + RND;
    sg_n = yq - SW'(pgu_p2) - SW'(pgv_p2) + RND;
    sb_n = yq + SW'(pb_p2) + RND;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1    <= 1'b0;
      y_p1      <= '0;
      cbs_p1    <= '0;
      crs_p1    <= '0;
      vld_p2    <= 1'b0;
      y_p2      <= '0;
      pr_p2     <= '0;
      pgu_p2    <= '0;
      pgv_p2    <= '0;
      pb_p2     <= '0;
      vld_p3    <= 1'b0;
      sr_p3     <= '0;
      sg_p3     <= '0;
      sb_p3     <= '0;
      out_valid <= 1'b0;
      r         <= '0;
      g         <= '0;
      b         <= '0;
    end else if (ce) begin
      // S1: capture luma, center chroma
      vld_p1    <= in_valid;
      y_p1      <= y;
      cbs_p1    <= center(cb);
      crs_p1    <= center(cr);
      // S2: chroma products
      vld_p2    <= vld_p1;
      y_p2      <= y_p1;
      pr_p2     <= mul(K_RV, crs_p1);
      pgu_p2    <= mul(K_GU, cbs_p1);
      pgv_p2    <= mul(K_GV, crs_p1);
      pb_p2     <= mul(K_BU, cbs_p1);
      // S3: Q8 sums with rounding
      vld_p3    <= vld_p2;
      sr_p3     <= sr_n;
      sg_p3     <= sg_n;
      sb_p3     <= sb_n;
      // S4: scale back and clamp into the output registers
      out_valid <= vld_p3;
      r         <= sat(sr_p3);
      g         <= sat(sg_p3);
      b         <= sat(sb_p3);
    end
  end

endmodule

// File: tb/tb_ycbcr2rgb_pipe.sv
// Directed bench for ycbcr2rgb_pipe: hand-computed colour vectors, latency,
// backpressure and mid-stream reset.
module tb_ycbcr2rgb_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] y, cb, cr;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] r, g, b;

  int n_cmp = 0;
  int n_err = 0;

  // {y, cb, cr, r, g, b}
  logic [47:0] vec [8];

  ycbcr2rgb_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .y         (y),
    .cb        (cb),
    .cr        (cr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .r         (r),
    .g         (g),
    .b         (b)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_rgb(input string tag, input logic [23:0] exp);
    chk({tag, "_r"}, int'(r), int'(exp[23:16]));
    chk({tag, "_g"}, int'(g), int'(exp[15:8]));
    chk({tag, "_b"}, int'(b), int'(exp[7:0]));
  endtask

  // Single pixel with out_ready high: edges 1..3 after acceptance show no output, edge 4 does.
  task automatic run_one(input logic [47:0] v, input string tag);
    in_valid = 1'b1;
    {y, cb, cr} = v[47:24];
    #1;
    chk({tag, "_in_ready"}, int'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    chk({tag, "_lat1"}, int'(out_valid), 0);
    tick();
    chk({tag, "_lat2"}, int'(out_valid), 0);
    tick();
    chk({tag, "_lat3"}, int'(out_valid), 0);
    tick();
    chk({tag, "_valid"}, int'(out_valid), 1);
    chk_rgb(tag, v[23:0]);
    tick();
    chk({tag, "_drop"}, int'(out_valid), 0);
  endtask

  initial begin
    int          idx;
    int          oidx;
    int          stalls;
    logic        held;
    logic [23:0] hold_rgb;

    vec[0] = 48'h80_80_80_80_80_80;
    vec[1] = 48'hFF_80_80_FF_FF_FF;
    vec[2] = 48'h00_80_80_00_00_00;
    vec[3] = 48'hFF_80_FF_FF_A4_FF;
    vec[4] = 48'h00_00_00_00_88_00;
    vec[5] = 48'h4C_55_FF_FE_00_00;
    vec[6] = 48'h64_80_80_64_64_64;
    vec[7] = 48'hC8_80_80_C8_C8_C8;

    rst_n     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    y = 8'd0; cb = 8'd0; cr = 8'd0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk_rgb("rst", 24'h000000);
    chk("rst_in_ready", int'(in_ready), 1);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    run_one(vec[0], "neutral");
    run_one(vec[1], "white");
    run_one(vec[2], "black");
    run_one(vec[3], "clamp_hi");
    run_one(vec[4], "clamp_lo");
    run_one(vec[5], "red");

    // Back-to-back stream with a 3-cycle downstream stall
    idx = 0; oidx = 0; stalls = 0; held = 1'b0; hold_rgb = '0;
    for (int c = 0; c < 60 && oidx < 8; c++) begin
      in_valid = (idx < 8);
      if (idx < 8) {y, cb, cr} = vec[idx][47:24];
      out_ready = !(c >= 5 && c <= 7);
      #1;
      if (held) begin
        chk("bp_hold_valid", int'(out_valid), 1);
        chk("bp_hold_rgb", int'({r, g, b}), int'(hold_rgb));
        held = 1'b0;
      end
      if (out_valid && !out_ready) begin
        chk("bp_in_ready", int'(in_ready), 0);
        hold_rgb = {r, g, b};
        held = 1'b1;
        stalls++;
      end
      if (out_valid && out_ready) begin
        chk_rgb("bp_pix", vec[oidx][23:0]);
        oidx++;
      end
      if (in_valid && in_ready) idx++;
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("bp_out_count", oidx, 8);
    chk("bp_in_count", idx, 8);
    chk("bp_stall_cycles", stalls, 3);
    tick();
    chk("bp_no_dup", int'(out_valid), 0);
    tick();
    chk("bp_no_dup2", int'(out_valid), 0);

    // Reset with pixels in flight
    for (int c = 0; c < 4; c++) begin
      in_valid = 1'b1;
      {y, cb, cr} = vec[c + 1][47:24];
      tick();
    end
    in_valid = 1'b0;
    chk("mid_pre_valid", int'(out_valid), 1);
    chk_rgb("mid_pre", vec[1][23:0]);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", int'(out_valid), 0);
    chk_rgb("mid_rst", 24'h000000);
    tick();
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("post_rst_no_stale", int'(out_valid), 0);
    end
    run_one(vec[6], "post_rst");
    run_one(vec[7], "post_rst2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
